// File: rtl/mesh_cfg_ctrl.sv
// mesh_cfg_ctrl: register-mapped run controller for an 8-PE mesh.
// Holds the per-run configuration and sequences each run as flush, run and done.
// The run ends when every enabled PE has reported, or when the cycle limit expires.
module mesh_cfg_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_wr_en,
  input  logic [3:0]   cfg_addr,
  input  logic [31:0]  cfg_wdata,
  output logic         cfg_wr_err,
  output logic [7:0]   pe_enable,
  output logic [7:0]   pe_dbg_mode_wire,
  output logic [23:0]  pe_send_num_wire,
  output logic [23:0]  pe_receive_num_wire,
  output logic [31:0]  pe_rate_wire,
  output logic [191:0] pe_dst_seq_wire,
  output logic [31:0]  pe_mode_wire,
  output logic [7:0]   pe_flush_wire,
  input  logic [7:0]   pe_task_send_finish_flag,
  input  logic [7:0]   pe_task_receive_finish_flag,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [31:0]  run_cycles
);

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t        state_q, state_d;
  logic [3:0]    flush_cnt_q, flush_cnt_d;
  logic [31:0]   run_cycles_q, run_cycles_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          err_q, err_d;

  logic [7:0]    mask_q;
  logic [7:0]    dbg_q;
  logic [23:0]   send_num_q;
  logic [23:0]   recv_num_q;
  logic [31:0]   rate_q;
  logic [31:0]   mode_q;
  logic [191:0]  dst_seq_q;
  logic [31:0]   limit_q;

  logic          cfg_write;
  logic          cmd_start;
  logic          cmd_abort;
  logic          idle_like;
  logic          complete;
  logic          timeout_hit;

  assign cfg_write   = cfg_wr_en && (cfg_addr <= 4'd12);
  assign cmd_start   = cfg_wr_en && (cfg_addr == 4'd13) && cfg_wdata[0];
  assign cmd_abort   = cfg_wr_en && (cfg_addr == 4'd13) && cfg_wdata[1];
  assign idle_like   = (state_q == IDLE) || (state_q == DONE);
  assign complete    = ((pe_task_send_finish_flag & pe_task_receive_finish_flag & mask_q) == mask_q);
  assign timeout_hit = (limit_q != 32'd0) && (run_cycles_q == limit_q - 32'd1);

  // Configuration registers; writes only land while no run is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q     <= '0;
      dbg_q      <= '0;
      send_num_q <= '0;
      recv_num_q <= '0;
      rate_q     <= '0;
      mode_q     <= '0;
      dst_seq_q  <= '0;
      limit_q    <= '0;
    end else if (cfg_write && idle_like) begin
      case (cfg_addr)
        4'd0:    mask_q                <= cfg_wdata[7:0];
        4'd1:    dbg_q                 <= cfg_wdata[7:0];
        4'd2:    send_num_q            <= cfg_wdata[23:0];
        4'd3:    recv_num_q            <= cfg_wdata[23:0];
        4'd4:    rate_q                <= cfg_wdata;
        4'd5:    mode_q                <= cfg_wdata;
        4'd6:    dst_seq_q[31:0]       <= cfg_wdata;
        4'd7:    dst_seq_q[63:32]      <= cfg_wdata;
        4'd8:    dst_seq_q[95:64]      <= cfg_wdata;
        4'd9:    dst_seq_q[127:96]     <= cfg_wdata;
        4'd10:   dst_seq_q[159:128]    <= cfg_wdata;
        4'd11:   dst_seq_q[191:160]    <= cfg_wdata;
        4'd12:   limit_q               <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // State register and run status; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flush_cnt_q  <= '0;
      run_cycles_q <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      run_cycles_q <= run_cycles_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic; abort overrides everything, completion beats timeout.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    run_cycles_d = run_cycles_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    err_d        = (cfg_write && !idle_like) ||
                   (cmd_start && !cmd_abort && (!idle_like || (mask_q == 8'd0)));

    if (cmd_abort) begin
      state_d      = IDLE;
      flush_cnt_d  = '0;
      run_cycles_d = '0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (cmd_start && (mask_q != 8'd0)) begin
            state_d      = FLUSH;
            flush_cnt_d  = '0;
            run_cycles_d = '0;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + 4'd1;
          end
        end
        RUN: begin
          if (run_cycles_q != 32'hFFFF_FFFF) begin
            run_cycles_d = run_cycles_q + 32'd1;
          end
          if (complete) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (timeout_hit) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cfg_wr_err          = err_q;
  assign busy                = (state_q == FLUSH) || (state_q == RUN);
  assign done                = done_q;
  assign timeout             = timeout_q;
  assign run_cycles          = run_cycles_q;
  assign pe_enable           = (state_q == RUN) ? mask_q : 8'd0;
  assign pe_flush_wire       = (state_q == FLUSH) ? 8'hFF : 8'd0;
  assign pe_dbg_mode_wire    = dbg_q;
  assign pe_send_num_wire    = send_num_q;
  assign pe_receive_num_wire = recv_num_q;
  assign pe_rate_wire        = rate_q;
  assign pe_mode_wire        = mode_q;
  assign pe_dst_seq_wire     = dst_seq_q;

endmodule

// File: tb/tb_mesh_cfg_ctrl.sv
// tb_mesh_cfg_ctrl: directed bench for mesh_cfg_ctrl with hand-computed expectations.
module tb_mesh_cfg_ctrl;

  logic         clk;
  logic         rst;
  logic         cfg_wr_en;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic         cfg_wr_err;
  logic [7:0]   pe_enable;
  logic [7:0]   pe_dbg_mode_wire;
  logic [23:0]  pe_send_num_wire;
  logic [23:0]  pe_receive_num_wire;
  logic [31:0]  pe_rate_wire;
  logic [191:0] pe_dst_seq_wire;
  logic [31:0]  pe_mode_wire;
  logic [7:0]   pe_flush_wire;
  logic [7:0]   send_flag;
  logic [7:0]   recv_flag;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [31:0]  run_cycles;

  int checks = 0;
  int errors = 0;

  mesh_cfg_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .cfg_wr_en                   (cfg_wr_en),
    .cfg_addr                    (cfg_addr),
    .cfg_wdata                   (cfg_wdata),
    .cfg_wr_err                  (cfg_wr_err),
    .pe_enable                   (pe_enable),
    .pe_dbg_mode_wire            (pe_dbg_mode_wire),
    .pe_send_num_wire            (pe_send_num_wire),
    .pe_receive_num_wire         (pe_receive_num_wire),
    .pe_rate_wire                (pe_rate_wire),
    .pe_dst_seq_wire             (pe_dst_seq_wire),
    .pe_mode_wire                (pe_mode_wire),
    .pe_flush_wire               (pe_flush_wire),
    .pe_task_send_finish_flag    (send_flag),
    .pe_task_receive_finish_flag (recv_flag),
    .busy                        (busy),
    .done                        (done),
    .timeout                     (timeout),
    .run_cycles                  (run_cycles)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns past the next rising edge, where all sampling happens.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle register write strobe; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick(1);
    cfg_wr_en = 1'b0;
    cfg_addr  = 4'd0;
    cfg_wdata = 32'd0;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    rst       = 1'b1;
    cfg_wr_en = 1'b0;
    cfg_addr  = 4'd0;
    cfg_wdata = 32'd0;
    send_flag = 8'd0;
    recv_flag = 8'd0;
    #2;
    checkOutput("rst_pe_enable", 32'(pe_enable), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_run_cycles", run_cycles, 32'h0);
    checkOutput("rst_flush", 32'(pe_flush_wire), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(2);
    checkOutput("post_rst_pe_enable", 32'(pe_enable), 32'h0);

    $display("[TB] ignored address write");
    applyStimulus(4'd14, 32'hFFFF_FFFF);
    checkOutput("addr14_err", 32'(cfg_wr_err), 32'h0);
    checkOutput("addr14_busy", 32'(busy), 32'h0);

    $display("[TB] bit-complement run");
    applyStimulus(4'd1, 32'hFFFF_FFFF);
    applyStimulus(4'd2, 32'h0024_9249);
    applyStimulus(4'd3, 32'h0024_9249);
    applyStimulus(4'd5, 32'h1111_1111);
    applyStimulus(4'd7, 32'hDEAD_BEEF);
    applyStimulus(4'd0, 32'h0000_00FF);
    checkOutput("dbg_wire", 32'(pe_dbg_mode_wire), 32'hFF);
    checkOutput("send_wire", 32'(pe_send_num_wire), 32'h249249);
    checkOutput("recv_wire", 32'(pe_receive_num_wire), 32'h249249);
    checkOutput("mode_wire", pe_mode_wire, 32'h1111_1111);
    checkOutput("dst_word1", pe_dst_seq_wire[63:32], 32'hDEAD_BEEF);
    checkOutput("dst_word0", pe_dst_seq_wire[31:0], 32'h0);
    applyStimulus(4'd13, 32'h1);
    checkOutput("flush1_flush", 32'(pe_flush_wire), 32'hFF);
    checkOutput("flush1_enable", 32'(pe_enable), 32'h0);
    checkOutput("flush1_busy", 32'(busy), 32'h1);
    tick(1);
    checkOutput("flush2_flush", 32'(pe_flush_wire), 32'hFF);
    tick(1);
    checkOutput("run_flush", 32'(pe_flush_wire), 32'h0);
    checkOutput("run_enable", 32'(pe_enable), 32'hFF);
    checkOutput("run_start_cycles", run_cycles, 32'd0);
    tick(10);
    checkOutput("run_cycles_10", run_cycles, 32'd10);
    send_flag = 8'hFF;
    recv_flag = 8'hFF;
    tick(1);
    checkOutput("bc_done", 32'(done), 32'h1);
    checkOutput("bc_timeout", 32'(timeout), 32'h0);
    checkOutput("bc_run_cycles", run_cycles, 32'd11);
    checkOutput("bc_enable", 32'(pe_enable), 32'h0);
    send_flag = 8'd0;
    recv_flag = 8'd0;
    tick(2);
    checkOutput("bc_hold_cycles", run_cycles, 32'd11);
    checkOutput("bc_hold_done", 32'(done), 32'h1);

    $display("[TB] timeout run");
    applyStimulus(4'd12, 32'd100);
    applyStimulus(4'd13, 32'h1);
    checkOutput("to_start_done", 32'(done), 32'h0);
    tick(2);
    checkOutput("to_run_cycles0", run_cycles, 32'd0);
    tick(99);
    checkOutput("to_cycles99", run_cycles, 32'd99);
    checkOutput("to_busy99", 32'(busy), 32'h1);
    tick(1);
    checkOutput("to_done", 32'(done), 32'h1);
    checkOutput("to_timeout", 32'(timeout), 32'h1);
    checkOutput("to_run_cycles", run_cycles, 32'd100);
    checkOutput("to_busy", 32'(busy), 32'h0);

    $display("[TB] partial mask run");
    applyStimulus(4'd12, 32'd0);
    applyStimulus(4'd0, 32'h0F);
    applyStimulus(4'd13, 32'h1);
    tick(2);
    checkOutput("pm_enable", 32'(pe_enable), 32'h0F);
    send_flag = 8'hF0;
    recv_flag = 8'hF0;
    tick(2);
    checkOutput("pm_upper_only", 32'(done), 32'h0);
    send_flag = 8'h0F;
    recv_flag = 8'h07;
    tick(2);
    checkOutput("pm_partial_done", 32'(done), 32'h0);
    checkOutput("pm_partial_busy", 32'(busy), 32'h1);
    recv_flag = 8'hFF;
    tick(1);
    checkOutput("pm_complete_done", 32'(done), 32'h1);
    checkOutput("pm_complete_timeout", 32'(timeout), 32'h0);
    send_flag = 8'd0;
    recv_flag = 8'd0;

    $display("[TB] busy protection");
    applyStimulus(4'd4, 32'hCAFE_0001);
    checkOutput("bp_rate_idle", pe_rate_wire, 32'hCAFE_0001);
    applyStimulus(4'd0, 32'hFF);
    applyStimulus(4'd13, 32'h1);
    tick(2);
    checkOutput("bp_in_run", 32'(pe_enable), 32'hFF);
    applyStimulus(4'd4, 32'h1234_5678);
    checkOutput("bp_wr_err", 32'(cfg_wr_err), 32'h1);
    checkOutput("bp_rate_kept", pe_rate_wire, 32'hCAFE_0001);
    tick(1);
    checkOutput("bp_wr_err_once", 32'(cfg_wr_err), 32'h0);
    applyStimulus(4'd13, 32'h1);
    checkOutput("bp_start_err", 32'(cfg_wr_err), 32'h1);
    checkOutput("bp_start_busy", 32'(busy), 32'h1);
    tick(1);
    checkOutput("bp_start_err_once", 32'(cfg_wr_err), 32'h0);
    applyStimulus(4'd13, 32'h2);
    checkOutput("bp_abort_busy", 32'(busy), 32'h0);
    checkOutput("bp_abort_enable", 32'(pe_enable), 32'h0);
    checkOutput("bp_abort_done", 32'(done), 32'h0);
    checkOutput("bp_abort_rate", pe_rate_wire, 32'hCAFE_0001);

    $display("[TB] simultaneity");
    applyStimulus(4'd12, 32'd3);
    applyStimulus(4'd13, 32'h1);
    tick(2);
    checkOutput("sim_run0", run_cycles, 32'd0);
    tick(2);
    checkOutput("sim_run2", run_cycles, 32'd2);
    send_flag = 8'hFF;
    recv_flag = 8'hFF;
    tick(1);
    checkOutput("sim_done", 32'(done), 32'h1);
    checkOutput("sim_timeout", 32'(timeout), 32'h0);
    checkOutput("sim_cycles", run_cycles, 32'd3);
    send_flag = 8'd0;
    recv_flag = 8'd0;
    applyStimulus(4'd13, 32'h3);
    checkOutput("sa_busy", 32'(busy), 32'h0);
    checkOutput("sa_done", 32'(done), 32'h0);
    checkOutput("sa_err", 32'(cfg_wr_err), 32'h0);
    tick(2);
    checkOutput("sa_stay_idle", 32'(busy), 32'h0);
    applyStimulus(4'd0, 32'h0);
    applyStimulus(4'd13, 32'h1);
    checkOutput("m0_err", 32'(cfg_wr_err), 32'h1);
    checkOutput("m0_busy", 32'(busy), 32'h0);
    tick(1);
    checkOutput("m0_err_once", 32'(cfg_wr_err), 32'h0);
    checkOutput("m0_flush", 32'(pe_flush_wire), 32'h0);

    $display("[TB] reset mid-run");
    applyStimulus(4'd12, 32'd0);
    applyStimulus(4'd0, 32'hFF);
    applyStimulus(4'd13, 32'h1);
    tick(2);
    tick(3);
    checkOutput("mr_before_cycles", run_cycles, 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("mr_enable", 32'(pe_enable), 32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h0);
    checkOutput("mr_run_cycles", run_cycles, 32'h0);
    checkOutput("mr_flush", 32'(pe_flush_wire), 32'h0);
    checkOutput("mr_dbg", 32'(pe_dbg_mode_wire), 32'h0);
    tick(2);
    rst = 1'b0;
    tick(3);
    checkOutput("mr_after_enable", 32'(pe_enable), 32'h0);
    checkOutput("mr_after_busy", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
